// File: rtl/alu_issue_if.sv
// Issue-stage handshake bundle: decoded instruction in, ALU input bundle out.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds valid and payload stable until then.
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      out_alu_opc;
    logic            out_alu_vld;
    logic [XLEN-1:0] out_in1;
    logic [XLEN-1:0] out_in2;
    logic [RD_W-1:0] out_rd;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val,
               in_imm, in_pc, in_rd, out_ready,
        output in_ready, out_valid, out_alu_opc, out_alu_vld, out_in1, out_in2, out_rd, out_illegal
    );

    modport master (
        output flush, in_valid, in_opcode, in_funct3, in_funct7, in_rs1_val, in_rs2_val,
               in_imm, in_pc, in_rd, out_ready,
        input  in_ready, out_valid, out_alu_opc, out_alu_vld, out_in1, out_in2, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I execute-issue stage: operand select + one-hot ALU op decode, registered
// through an output register backed by a one-entry skid so in_ready is a flop.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [9:0] ALU_ADD  = 10'b00_0000_0001;
    localparam logic [9:0] ALU_SUB  = 10'b00_0000_0010;
    localparam logic [9:0] ALU_XOR  = 10'b00_0000_0100;
    localparam logic [9:0] ALU_OR   = 10'b00_0000_1000;
    localparam logic [9:0] ALU_AND  = 10'b00_0001_0000;
    localparam logic [9:0] ALU_SLL  = 10'b00_0010_0000;
    localparam logic [9:0] ALU_SRL  = 10'b00_0100_0000;
    localparam logic [9:0] ALU_SRA  = 10'b00_1000_0000;
    localparam logic [9:0] ALU_SLT  = 10'b01_0000_0000;
    localparam logic [9:0] ALU_SLTU = 10'b10_0000_0000;

    typedef struct packed {
        logic [9:0]      opc;
        logic            alu_vld;
        logic            illegal;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

    state_t    state, state_nx;
    bundle_t   out_q, skid_q, dec;
    logic      in_ready_q;
    logic      acc, load_out, load_skid, out_from_skid;
    logic [9:0] op_sel;
    logic      is_alu, legal, alt_f7;

    // Decode is purely from the offered instruction; it is only captured on accept.
    always_comb begin
        dec     = '0;
        dec.rd  = bus.in_rd;
        dec.in1 = bus.in_rs1_val;
        dec.in2 = bus.in_rs2_val;
        op_sel  = ALU_ADD;
        is_alu  = 1'b0;
        legal   = 1'b1;
        alt_f7  = (bus.in_funct7 == 7'h20);
        case (bus.in_funct3)
            3'd0:    op_sel = ALU_ADD;
            3'd1:    op_sel = ALU_SLL;
            3'd2:    op_sel = ALU_SLT;
            3'd3:    op_sel = ALU_SLTU;
            3'd4:    op_sel = ALU_XOR;
            3'd5:    op_sel = alt_f7 ? ALU_SRA : ALU_SRL;
            3'd6:    op_sel = ALU_OR;
            default: op_sel = ALU_AND;
        endcase
        case (bus.in_opcode)
            OPC_OP: begin
                is_alu = 1'b1;
                if (bus.in_funct3 == 3'd0 && alt_f7) op_sel = ALU_SUB;
                legal = (bus.in_funct7 == 7'h00) ||
                        (alt_f7 && (bus.in_funct3 == 3'd0 || bus.in_funct3 == 3'd5));
            end
            OPC_OP_IMM: begin
                is_alu  = 1'b1;
                dec.in2 = bus.in_imm;
                if (bus.in_funct3 == 3'd1 || bus.in_funct3 == 3'd5) begin
                    dec.in2 = {{(XLEN-5){1'b0}}, bus.in_imm[4:0]};
                    legal   = (bus.in_funct7 == 7'h00) || (alt_f7 && bus.in_funct3 == 3'd5);
                end
            end
            OPC_LUI: begin
                is_alu  = 1'b1;
                op_sel  = ALU_ADD;
                dec.in1 = '0;
                dec.in2 = bus.in_imm;
            end
            OPC_AUIPC: begin
                is_alu  = 1'b1;
                op_sel  = ALU_ADD;
                dec.in1 = bus.in_pc;
                dec.in2 = bus.in_imm;
            end
            default: is_alu = 1'b0;
        endcase
        if (is_alu) begin
            if (legal) begin
                dec.opc     = op_sel;
                dec.alu_vld = 1'b1;
            end else begin
                dec.illegal = 1'b1;
            end
        end
    end

    assign acc = bus.in_valid && in_ready_q;

    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (bus.flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_nx = FULL;
                    load_out = 1'b1;
                end
                FULL: begin
                    if (bus.out_ready && acc) begin
                        load_out = 1'b1;
                    end else if (bus.out_ready) begin
                        state_nx = EMPTY;
                    end else if (acc) begin
                        state_nx  = SKID;
                        load_skid = 1'b1;
                    end
                end
                SKID: if (bus.out_ready) begin
                    state_nx      = FULL;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != SKID);
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state != EMPTY);
    assign bus.out_alu_opc = out_q.opc;
    assign bus.out_alu_vld = out_q.alu_vld;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_in1     = out_q.in1;
    assign bus.out_in2     = out_q.in2;
    assign dbg_state       = state;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode vectors, skid/stall ordering,
// flush and reset in SKID, then a model-checked stream under random out_ready.
module tb_alu_issue_stage;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] LOAD  = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    logic rand_mode = 1'b0;
    logic ready_force = 1'b0;
    logic rnd_bit = 1'b0;
    logic stalled = 1'b0;
    logic [80:0] held;
    logic [80:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.out_ready = rand_mode ? rnd_bit : ready_force;

    wire [80:0] got = {bus.out_alu_opc, bus.out_alu_vld, bus.out_illegal, bus.out_rd,
                       bus.out_in1, bus.out_in2};

    function automatic logic [80:0] mk(logic [9:0] opc, logic vld, logic ill, logic [4:0] rd,
                                       logic [31:0] a, logic [31:0] b);
        return {opc, vld, ill, rd, a, b};
    endfunction

    // Reference decoder: funct3 base op, shifted up one bit for the f7=0x20 variant.
    function automatic logic [80:0] ref_dec(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                            logic [31:0] rs1, logic [31:0] rs2,
                                            logic [31:0] imm, logic [31:0] pc, logic [4:0] rd);
        logic [9:0] base;
        logic ok;
        logic [31:0] b2;
        case (f3)
            3'd0: base = 10'd1;
            3'd1: base = 10'd1 << 5;
            3'd2: base = 10'd1 << 8;
            3'd3: base = 10'd1 << 9;
            3'd4: base = 10'd1 << 2;
            3'd5: base = 10'd1 << 6;
            3'd6: base = 10'd1 << 3;
            default: base = 10'd1 << 4;
        endcase
        if (op == OP) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20) base = base << 1;
            return ok ? mk(base, 1'b1, 1'b0, rd, rs1, rs2) : mk(10'd0, 1'b0, 1'b1, rd, rs1, rs2);
        end else if (op == OPIMM) begin
            b2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, imm[4:0]} : imm;
            ok = 1'b1;
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            if (f3 == 3'd5 && f7 == 7'h20) base = base << 1;
            return ok ? mk(base, 1'b1, 1'b0, rd, rs1, b2) : mk(10'd0, 1'b0, 1'b1, rd, rs1, b2);
        end else if (op == LUI) begin
            return mk(10'd1, 1'b1, 1'b0, rd, 32'd0, imm);
        end else if (op == AUIPC) begin
            return mk(10'd1, 1'b1, 1'b0, rd, pc, imm);
        end
        return mk(10'd0, 1'b0, 1'b0, rd, rs1, rs2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd);
        bus.in_opcode  = op;
        bus.in_funct3  = f3;
        bus.in_funct7  = f7;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        bus.in_imm     = imm;
        bus.in_pc      = pc;
        bus.in_rd      = rd;
        bus.in_valid   = 1'b1;
    endtask

    // Called at a negedge; in_ready only moves on posedge, so it predicts the next edge.
    task automatic wait_accept(input logic [80:0] e);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 expected 1");
        end else begin
            exp_q.push_back(e);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic [80:0] e);
        drive(op, f3, f7, rs1, rs2, imm, pc, rd);
        wait_accept(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 0);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 1);
        chk({tag, "_opc"}, {22'd0, bus.out_alu_opc}, 0);
        chk({tag, "_alu_vld"}, {31'd0, bus.out_alu_vld}, 0);
        chk({tag, "_in1"}, bus.out_in1, 0);
        chk({tag, "_in2"}, bus.out_in2, 0);
        chk({tag, "_rd"}, {27'd0, bus.out_rd}, 0);
        chk({tag, "_illegal"}, {31'd0, bus.out_illegal}, 0);
    endtask

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    // Monitor: pops one expectation per output transfer and checks stall stability.
    initial begin
        logic [80:0] e;
        logic [80:0] mask;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && bus.out_valid) begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL stall_stable got %h expected %h", got, held);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (bus.out_alu_vld ? !$onehot(bus.out_alu_opc) : (bus.out_alu_opc != 10'd0)) begin
                        errors++;
                        $display("FAIL onehot got opc=%b vld=%b expected one-hot iff vld",
                                 bus.out_alu_opc, bus.out_alu_vld);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out got %h expected nothing", got);
                    end else begin
                        e = exp_q.pop_front();
                        mask = e[69] ? ({81{1'b1}} << 64) : {81{1'b1}};
                        if ((got & mask) !== (e & mask)) begin
                            errors++;
                            $display("FAIL bundle got %h expected %h", got, e);
                        end
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held = got;
            end
        end
    end

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0] rd;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        drive(OP, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        ready_force = 1'b1;

        // Directed decode vectors with hand-computed bundles.
        send(OP, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3,
             mk(10'h001, 1, 0, 5'd3, 32'd5, 32'd7));
        send(OPIMM, 3'd5, 7'h20, 32'hF000_0000, 32'd9, 32'h405, 32'd0, 5'd4,
             mk(10'h080, 1, 0, 5'd4, 32'hF000_0000, 32'd5));
        send(OP, 3'd1, 7'h20, 32'd1, 32'd2, 32'd0, 32'd0, 5'd6,
             mk(10'h000, 0, 1, 5'd6, 32'd1, 32'd2));
        send(AUIPC, 3'd0, 7'h00, 32'h1234, 32'h5678, 32'h0000_1000, 32'h8000_0000, 5'd7,
             mk(10'h001, 1, 0, 5'd7, 32'h8000_0000, 32'h1000));
        send(LUI, 3'd3, 7'h15, 32'h1234, 32'h5678, 32'hABCD_E000, 32'h8000_0000, 5'd8,
             mk(10'h001, 1, 0, 5'd8, 32'd0, 32'hABCD_E000));
        send(OP, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 32'd0, 5'd9,
             mk(10'h002, 1, 0, 5'd9, 32'd10, 32'd3));
        send(OP, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd10,
             mk(10'h200, 1, 0, 5'd10, 32'hFFFF_FFFF, 32'd1));
        send(OPIMM, 3'd4, 7'h55, 32'd77, 32'd88, 32'hFFFF_FAAB, 32'd0, 5'd11,
             mk(10'h004, 1, 0, 5'd11, 32'd77, 32'hFFFF_FAAB));
        send(OPIMM, 3'd1, 7'h01, 32'd1, 32'd2, 32'h0000_0023, 32'd0, 5'd12,
             mk(10'h000, 0, 1, 5'd12, 32'd1, 32'd3));
        send(LOAD, 3'd2, 7'h00, 32'hAAAA_0000, 32'h0000_BBBB, 32'd16, 32'd0, 5'd13,
             mk(10'h000, 0, 0, 5'd13, 32'hAAAA_0000, 32'h0000_BBBB));
        send(OP, 3'd6, 7'h01, 32'd4, 32'd5, 32'd0, 32'd0, 5'd14,
             mk(10'h000, 0, 1, 5'd14, 32'd4, 32'd5));
        send(OP, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd15,
             mk(10'h080, 1, 0, 5'd15, 32'h8000_0000, 32'd4));
        drain();

        // A, B, C against a stalled consumer: B fills the skid, C must wait.
        ready_force = 1'b0;
        send(OP, 3'd7, 7'h00, 32'hA, 32'h1, 32'd0, 32'd0, 5'd1, mk(10'h010, 1, 0, 5'd1, 32'hA, 32'h1));
        send(OP, 3'd6, 7'h00, 32'hB, 32'h2, 32'd0, 32'd0, 5'd2, mk(10'h008, 1, 0, 5'd2, 32'hB, 32'h2));
        chk("skid_in_ready", {31'd0, bus.in_ready}, 0);
        drive(OP, 3'd4, 7'h00, 32'hC, 32'h3, 32'd0, 32'd0, 5'd3);
        repeat (3) begin
            @(negedge clk);
            chk("skid_hold_in_ready", {31'd0, bus.in_ready}, 0);
        end
        ready_force = 1'b1;
        wait_accept(mk(10'h004, 1, 0, 5'd3, 32'hC, 32'h3));
        drain();

        // Flush while in SKID with a new instruction offered.
        ready_force = 1'b0;
        send(OP, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, mk(10'h001, 1, 0, 5'd1, 32'd1, 32'd1));
        send(OP, 3'd0, 7'h00, 32'd2, 32'd2, 32'd0, 32'd0, 5'd2, mk(10'h001, 1, 0, 5'd2, 32'd2, 32'd2));
        drive(OP, 3'd0, 7'h00, 32'd3, 32'd3, 32'd0, 32'd0, 5'd3);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 1);
        ready_force = 1'b1;
        repeat (5) @(negedge clk);
        chk("flush_nothing_emerges", {31'd0, bus.out_valid}, 0);

        // Reset while in SKID.
        ready_force = 1'b0;
        send(OPIMM, 3'd6, 7'h00, 32'd9, 32'd9, 32'd9, 32'd0, 5'd9, mk(10'h008, 1, 0, 5'd9, 32'd9, 32'd9));
        send(OPIMM, 3'd7, 7'h00, 32'd8, 32'd8, 32'd8, 32'd0, 5'd8, mk(10'h010, 1, 0, 5'd8, 32'd8, 32'd8));
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk_reset_outputs("rst_skid");
        rst = 1'b0;

        // Model-checked stream with random backpressure and idle gaps.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP;
                1: op = OPIMM;
                2: op = LUI;
                3: op = AUIPC;
                4: op = LOAD;
                default: op = 7'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            f3  = 3'($urandom_range(0, 7));
            rs1 = $urandom;
            rs2 = $urandom;
            imm = $urandom;
            pc  = $urandom;
            rd  = 5'($urandom_range(0, 31));
            send(op, f3, f7, rs1, rs2, imm, pc, rd, ref_dec(op, f3, f7, rs1, rs2, imm, pc, rd));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_mode = 1'b0;
        ready_force = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end
endmodule
